// File: rtl/riscv_tag_enable_ctrl.sv
// riscv_tag_enable_ctrl: classifies ID instructions and registers per-operand
// tag-propagation enables from the active TPR into a one-entry EX-side stage.
// Owns the TPR with a staged write, commit barrier and optional sticky lock,
// and counts accepted instructions that had any tag propagation disabled.
module riscv_tag_enable_ctrl #(
    parameter logic [31:0] TPR_RST = 32'h0000_0FFF,
    parameter bit          LOCK_EN = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_rdata_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [2:0]       ex_class_o,
    output logic             enable_a_o,
    output logic             enable_b_o,
    output logic             is_store_o,
    output logic             is_load_o,
    input  logic             tpr_we_i,
    input  logic [31:0]      tpr_wdata_i,
    output logic [31:0]      tpr_o,
    output logic             tpr_pending_o,
    output logic [CNT_W-1:0] dis_cnt_o,
    input  logic             dis_cnt_clr_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned CLS_W = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b010_0011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b011_0011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b110_0111;

    typedef enum logic [CLS_W-1:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_OP     = 3'd2,
        CLS_OP_IMM = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_OTHER  = 3'd7
    } cls_e;

    cls_e             cls_d;
    logic             en_a_d;
    logic             en_b_d;
    logic             accept;
    logic             drain_ok;
    logic             locked;
    logic             commit;
    logic             write_ok;
    logic [XLEN-1:0]  shadow_q;
    logic             unused_instr;

    // Only the major opcode participates in classification.
    assign unused_instr = ^instr_rdata_i[XLEN-1:OPC_W];

    // Handshake and TPR policy qualifiers.
    assign drain_ok   = !ex_valid_o || ex_ready_i;
    assign id_ready_o = !tpr_pending_o && drain_ok;
    assign accept     = id_valid_i && id_ready_o;
    assign locked     = LOCK_EN && tpr_o[XLEN-1];
    assign commit     = tpr_pending_o && drain_ok;
    assign write_ok   = tpr_we_i && !locked;

    // Opcode to instruction class.
    always_comb begin
        cls_d = CLS_OTHER;
        case (instr_rdata_i[OPC_W-1:0])
            OPC_LOAD:   cls_d = CLS_LOAD;
            OPC_STORE:  cls_d = CLS_STORE;
            OPC_OP:     cls_d = CLS_OP;
            OPC_OP_IMM: cls_d = CLS_OP_IMM;
            OPC_BRANCH: cls_d = CLS_BRANCH;
            OPC_JALR:   cls_d = CLS_JALR;
            default:    cls_d = CLS_OTHER;
        endcase
    end

    // Per-class enable pair from the active TPR; unknown classes always propagate.
    always_comb begin
        en_a_d = 1'b1;
        en_b_d = 1'b1;
        case (cls_d)
            CLS_LOAD:   {en_b_d, en_a_d} = tpr_o[1:0];
            CLS_STORE:  {en_b_d, en_a_d} = tpr_o[3:2];
            CLS_OP:     {en_b_d, en_a_d} = tpr_o[5:4];
            CLS_OP_IMM: {en_b_d, en_a_d} = tpr_o[7:6];
            CLS_BRANCH: {en_b_d, en_a_d} = tpr_o[9:8];
            CLS_JALR:   {en_b_d, en_a_d} = tpr_o[11:10];
            default: begin
                en_a_d = 1'b1;
                en_b_d = 1'b1;
            end
        endcase
    end

    // EX-side entry: load on accept, retire on consume, payload held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o <= 1'b0;
            ex_class_o <= CLS_W'(CLS_OTHER);
            enable_a_o <= 1'b1;
            enable_b_o <= 1'b1;
            is_store_o <= 1'b0;
            is_load_o  <= 1'b0;
        end else if (accept) begin
            ex_valid_o <= 1'b1;
            ex_class_o <= CLS_W'(cls_d);
            enable_a_o <= en_a_d;
            enable_b_o <= en_b_d;
            is_store_o <= (cls_d == CLS_STORE);
            is_load_o  <= (cls_d == CLS_LOAD);
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    // TPR staging: a new write always wins the shadow; commit moves the old shadow
    // to active once the EX entry drains. A commit reaching a locked TPR is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpr_o         <= TPR_RST;
            shadow_q      <= TPR_RST;
            tpr_pending_o <= 1'b0;
        end else begin
            if (commit && !locked) begin
                tpr_o <= shadow_q;
            end
            if (write_ok) begin
                shadow_q      <= tpr_wdata_i;
                tpr_pending_o <= 1'b1;
            end else if (commit) begin
                tpr_pending_o <= 1'b0;
            end
        end
    end

    // Saturating count of accepted instructions with any tag enable cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_cnt_o <= '0;
        end else if (dis_cnt_clr_i) begin
            dis_cnt_o <= '0;
        end else if (accept && (!en_a_d || !en_b_d) && (dis_cnt_o != {CNT_W{1'b1}})) begin
            dis_cnt_o <= dis_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_tag_enable_ctrl.sv
// Directed bench for riscv_tag_enable_ctrl: a default build (lock on, 16-bit
// counter) and a build with lock off and a 2-bit counter, driven in lockstep.
module tb_riscv_tag_enable_ctrl;

    localparam logic [31:0] I_STORE = 32'h0011_2023;
    localparam logic [31:0] I_LOAD  = 32'h0000_2003;
    localparam logic [31:0] I_OP    = 32'h0000_0033;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        id_valid;
    logic        ex_ready;
    logic        tpr_we;
    logic [31:0] tpr_wdata;
    logic        cnt_clr;

    logic        id_ready, ex_valid, en_a, en_b, is_store, is_load, pending;
    logic [2:0]  ex_class;
    logic [31:0] tpr;
    logic [15:0] cnt;

    logic        id_ready2, ex_valid2, en_a2, en_b2, is_store2, is_load2, pending2;
    logic [2:0]  ex_class2;
    logic [31:0] tpr2;
    logic [1:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    riscv_tag_enable_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_rdata_i(instr), .id_valid_i(id_valid),
        .id_ready_o(id_ready), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_class_o(ex_class), .enable_a_o(en_a), .enable_b_o(en_b),
        .is_store_o(is_store), .is_load_o(is_load), .tpr_we_i(tpr_we),
        .tpr_wdata_i(tpr_wdata), .tpr_o(tpr), .tpr_pending_o(pending),
        .dis_cnt_o(cnt), .dis_cnt_clr_i(cnt_clr)
    );

    riscv_tag_enable_ctrl #(.LOCK_EN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr_rdata_i(instr), .id_valid_i(id_valid),
        .id_ready_o(id_ready2), .ex_valid_o(ex_valid2), .ex_ready_i(ex_ready),
        .ex_class_o(ex_class2), .enable_a_o(en_a2), .enable_b_o(en_b2),
        .is_store_o(is_store2), .is_load_o(is_load2), .tpr_we_i(tpr_we),
        .tpr_wdata_i(tpr_wdata), .tpr_o(tpr2), .tpr_pending_o(pending2),
        .dis_cnt_o(cnt2), .dis_cnt_clr_i(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // EX entry of both builds against the same expectation.
    task automatic chk_ex(input string tag, input logic v, input logic [2:0] cls,
                          input logic ea, input logic eb, input logic st, input logic ld);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(v));
        chk({tag, ".class"}, 32'(ex_class), 32'(cls));
        chk({tag, ".en_a"},  32'(en_a),     32'(ea));
        chk({tag, ".en_b"},  32'(en_b),     32'(eb));
        chk({tag, ".store"}, 32'(is_store), 32'(st));
        chk({tag, ".load"},  32'(is_load),  32'(ld));
        chk({tag, ".valid2"}, 32'(ex_valid2), 32'(v));
        chk({tag, ".class2"}, 32'(ex_class2), 32'(cls));
        chk({tag, ".en2"},    32'({en_b2, en_a2}), 32'({eb, ea}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0; id_valid = 1'b0; ex_ready = 1'b0;
        tpr_we = 1'b0; tpr_wdata = 32'h0; cnt_clr = 1'b0;
        #12;
        // reset state
        chk_ex("rst", 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst.tpr", tpr, 32'h0000_0FFF);
        chk("rst.pending", 32'(pending), 32'h0);
        chk("rst.cnt", 32'(cnt), 32'h0);
        chk("rst.id_ready", 32'(id_ready), 32'h1);
        #6 rst_n = 1'b1;

        // 1: STORE with default TPR, then full-throughput stream
        instr = I_STORE; id_valid = 1'b1; ex_ready = 1'b1;
        tick();
        chk_ex("t1.store", 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1.id_ready", 32'(id_ready), 32'h1);
        instr = I_LOAD;
        tick();
        chk_ex("t1.load", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        instr = I_OP;
        tick();
        chk_ex("t1.op", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        instr = I_JAL;
        tick();
        chk_ex("t1.other", 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();
        chk_ex("t1.drain", 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1.cnt", 32'(cnt), 32'h0);

        // 2: policy write behind a stalled entry
        instr = I_STORE; id_valid = 1'b1; ex_ready = 1'b0;
        tick();
        chk_ex("t2.hold", 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2.id_ready_stall", 32'(id_ready), 32'h0);
        id_valid = 1'b0; tpr_we = 1'b1; tpr_wdata = 32'h0000_0FF3;
        tick();
        chk("t2.pending", 32'(pending), 32'h1);
        chk("t2.tpr_old", tpr, 32'h0000_0FFF);
        chk("t2.id_ready_pend", 32'(id_ready), 32'h0);
        tpr_we = 1'b0; ex_ready = 1'b1;
        chk("t2.id_ready_pend_rdy", 32'(id_ready), 32'h0);
        tick();
        chk("t2.tpr_new", tpr, 32'h0000_0FF3);
        chk("t2.pending_clr", 32'(pending), 32'h0);
        chk("t2.id_ready_after", 32'(id_ready), 32'h1);
        id_valid = 1'b1;
        tick();
        chk_ex("t2.store_dis", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2.cnt", 32'(cnt), 32'h1);
        chk("t2.cnt2", 32'(cnt2), 32'h1);
        id_valid = 1'b0;
        tick();

        // 3: back-to-back writes while stalled, last one wins
        instr = I_OP; id_valid = 1'b1; ex_ready = 1'b0;
        tick();
        chk_ex("t3.op", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        id_valid = 1'b0; tpr_we = 1'b1; tpr_wdata = 32'h0000_0111;
        tick();
        tpr_wdata = 32'h0000_0222;
        tick();
        chk("t3.pending", 32'(pending), 32'h1);
        chk("t3.tpr_stalled", tpr, 32'h0000_0FF3);
        tpr_we = 1'b0; ex_ready = 1'b1;
        tick();
        chk("t3.tpr", tpr, 32'h0000_0222);
        chk("t3.pending_clr", 32'(pending), 32'h0);

        // 5: saturating counter (LOAD disabled on en_a under 0x222)
        instr = I_LOAD; id_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_ex("t5.load", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5.cnt16", 32'(cnt), 32'd6);
        chk("t5.cnt_sat", 32'(cnt2), 32'd3);
        cnt_clr = 1'b1;
        tick();
        chk("t5.clr", 32'(cnt), 32'h0);
        chk("t5.clr2", 32'(cnt2), 32'h0);
        cnt_clr = 1'b0; id_valid = 1'b0;
        tick();
        chk("t5.drain", 32'(ex_valid), 32'h0);

        // write and commit in the same cycle: commit takes the older shadow
        instr = I_OP; id_valid = 1'b1; ex_ready = 1'b0;
        tick();
        chk("wc.cnt", 32'(cnt), 32'h1);
        id_valid = 1'b0; tpr_we = 1'b1; tpr_wdata = 32'h0000_0AAA;
        tick();
        ex_ready = 1'b1; tpr_wdata = 32'h0000_0BBB;
        tick();
        chk("wc.tpr_old_shadow", tpr, 32'h0000_0AAA);
        chk("wc.still_pending", 32'(pending), 32'h1);
        chk("wc.id_ready", 32'(id_ready), 32'h0);
        tpr_we = 1'b0;
        tick();
        chk("wc.tpr_new", tpr, 32'h0000_0BBB);
        chk("wc.pending_clr", 32'(pending), 32'h0);

        // 4: sticky lock vs plain storage
        tpr_we = 1'b1; tpr_wdata = 32'h8000_0000;
        tick();
        tpr_we = 1'b0;
        tick();
        chk("t4.locked", tpr, 32'h8000_0000);
        tpr_we = 1'b1; tpr_wdata = 32'h0000_0FFF;
        tick();
        chk("t4.ignored_pend", 32'(pending), 32'h0);
        chk("t4.nolock_pend", 32'(pending2), 32'h1);
        tpr_we = 1'b0;
        tick();
        chk("t4.tpr_frozen", tpr, 32'h8000_0000);
        chk("t4.tpr_nolock", tpr2, 32'h0000_0FFF);
        chk("t4.id_ready_locked", 32'(id_ready), 32'h1);

        // 6: async reset with a held entry and a pending write
        instr = I_STORE; id_valid = 1'b1; ex_ready = 1'b0;
        tick();
        id_valid = 1'b0; tpr_we = 1'b1; tpr_wdata = 32'h0000_0123;
        tick();
        chk("t6.pre_valid", 32'(ex_valid2), 32'h1);
        chk("t6.pre_pend", 32'(pending2), 32'h1);
        tpr_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_ex("t6.rst", 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6.tpr", tpr, 32'h0000_0FFF);
        chk("t6.tpr2", tpr2, 32'h0000_0FFF);
        chk("t6.pend2", 32'(pending2), 32'h0);
        chk("t6.cnt", 32'(cnt), 32'h0);
        #10 rst_n = 1'b1;
        tick();
        chk("t6.after_pend", 32'(pending2), 32'h0);
        chk("t6.after_tpr2", tpr2, 32'h0000_0FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
